// File: rtl/password_digit_sender_pkg.sv
// ----------------------------------------------------------------------------
// door_lock_pkg : constants and state encoding shared across the door-lock slice
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package door_lock_pkg;

  localparam int DOOR_DIGITS  = 3;
  localparam int DOOR_DIGIT_W = 4;
  localparam int DOOR_CODE_W  = DOOR_DIGITS * DOOR_DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } sender_state_t;

endpackage

`default_nettype wire

// File: rtl/password_digit_sender_if.sv
// ----------------------------------------------------------------------------
// password_digit_sender_if : digit-serial valid/ready stream
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface password_digit_sender_if #(
  parameter int DIGIT_W = door_lock_pkg::DOOR_DIGIT_W
) ();

  logic [DIGIT_W-1:0] digit;
  logic               valid;
  logic               ready;

  modport master (output digit, output valid, input ready);
  modport slave  (input digit, input valid, output ready);

endinterface

`default_nettype wire

// File: rtl/password_digit_sender_gap.sv
// ----------------------------------------------------------------------------
// password_gap_timer : loadable down-counter timing the idle gap between digits
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module password_gap_timer #(
  parameter int CYCLES = 1
) (
  input  wire logic i_clk,
  input  wire logic i_reset,
  input  wire logic i_load,
  input  wire logic i_run,
  output logic      o_expire
);

  localparam int               CNT_W   = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] C_START = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= C_START;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Expires on the final gap cycle so the FSM re-enters SEND on the next edge
  assign o_expire = i_run && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/password_digit_sender.sv
// ----------------------------------------------------------------------------
// password_digit_sender : loads a full code, emits its digits MSB-first over valid/ready
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module password_digit_sender
  import door_lock_pkg::*;
#(
  parameter int DIGITS     = DOOR_DIGITS,
  parameter int DIGIT_W    = DOOR_DIGIT_W,
  parameter int GAP_CYCLES = 0
) (
  input  wire logic                        i_clk,
  input  wire logic                        i_reset,
  input  wire logic [DIGITS*DIGIT_W-1:0]   i_password,
  input  wire logic                        i_load,
  output logic                             o_busy,
  output logic                             o_done,
  password_digit_sender_if.master          digit_bus
);

  localparam int               CODE_W = DIGITS * DIGIT_W;
  localparam int               CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

  sender_state_t      r_state, w_state_next;
  logic [CODE_W-1:0]  r_shift, w_shift_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_valid, r_busy, r_done;
  logic               w_handshake, w_gap_load, w_gap_expire;

  assign w_handshake = r_valid && digit_bus.ready;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      password_gap_timer #(
        .CYCLES (GAP_CYCLES)
      ) u_gap_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_gap_load),
        .i_run    (r_state == ST_GAP),
        .o_expire (w_gap_expire)
      );
    end else begin : g_no_gap
      wire w_gap_load_unused = w_gap_load;
      assign w_gap_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_gap_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_shift_next = i_password;
          w_cnt_next   = '0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_handshake) begin
          if (r_cnt == C_LAST) begin
            w_state_next = ST_DONE;
          end else begin
            w_shift_next = r_shift << DIGIT_W;
            w_cnt_next   = r_cnt + 1'b1;
            if (GAP_CYCLES > 0) begin
              w_gap_load   = 1'b1;
              w_state_next = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (w_gap_expire) begin
          w_state_next = ST_SEND;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_valid <= (w_state_next == ST_SEND);
      r_digit <= (w_state_next == ST_SEND) ? w_shift_next[CODE_W-1 -: DIGIT_W] : '0;
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign digit_bus.digit = r_digit;
  assign digit_bus.valid = r_valid;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_password_digit_sender.sv
// ----------------------------------------------------------------------------
// tb_password_digit_sender : directed bench, GAP_CYCLES=0 and 2 instances vs. a queue-style model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_password_digit_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load0 = 1'b0, load2 = 1'b0;
  logic [11:0] pw0 = '0, pw2 = '0;
  logic        ready0 = 1'b0, ready2 = 1'b0;
  logic        busy0, done0, busy2, done2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  password_digit_sender_if #(.DIGIT_W(4)) bus0 ();
  password_digit_sender_if #(.DIGIT_W(4)) bus2 ();
  assign bus0.ready = ready0;
  assign bus2.ready = ready2;

  password_digit_sender #(.DIGITS(3), .DIGIT_W(4), .GAP_CYCLES(0)) dut0 (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_password (pw0),
    .i_load     (load0),
    .o_busy     (busy0),
    .o_done     (done0),
    .digit_bus  (bus0)
  );

  password_digit_sender #(.DIGITS(3), .DIGIT_W(4), .GAP_CYCLES(2)) dut2 (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_password (pw2),
    .i_load     (load2),
    .o_busy     (busy2),
    .o_done     (done2),
    .digit_bus  (bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] o_dig(input int k);
    return (k == 0) ? bus0.digit : bus2.digit;
  endfunction
  function automatic logic o_val(input int k);
    return (k == 0) ? bus0.valid : bus2.valid;
  endfunction
  function automatic logic o_bsy(input int k);
    return (k == 0) ? busy0 : busy2;
  endfunction
  function automatic logic o_dn(input int k);
    return (k == 0) ? done0 : done2;
  endfunction

  // Model: remaining digit count, gap cycles left, and the loaded code
  logic [11:0] m_code [2];
  int          m_left [2];
  int          m_gap  [2];
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_valid[2];
  logic [3:0]  m_digit[2];

  task automatic model_step(input int k, input int g, input logic ld,
                            input logic [11:0] pw, input logic rdy);
    if (rst) begin
      m_code[k] = '0; m_left[k] = 0; m_gap[k] = 0;
      m_busy[k] = 0;  m_done[k] = 0;
    end else if (m_done[k]) begin
      m_done[k] = 0; m_busy[k] = 0;
    end else if (!m_busy[k]) begin
      if (ld) begin
        m_code[k] = pw; m_left[k] = 3; m_busy[k] = 1;
      end
    end else if (m_valid[k]) begin
      if (rdy) begin
        m_left[k]--;
        if (m_left[k] == 0) m_done[k] = 1;
        else m_gap[k] = g;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end
    m_valid[k] = m_busy[k] && !m_done[k] && (m_left[k] > 0) && (m_gap[k] == 0);
    m_digit[k] = m_valid[k] ? m_code[k][(m_left[k]-1)*4 +: 4] : 4'h0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0, 0, load0, pw0, ready0);
      model_step(1, 2, load2, pw2, ready2);
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("mdl%0d_digit", k), 32'(o_dig(k)), 32'(m_digit[k]));
        check($sformatf("mdl%0d_valid", k), 32'(o_val(k)), 32'(m_valid[k]));
        check($sformatf("mdl%0d_busy", k),  32'(o_bsy(k)), 32'(m_busy[k]));
        check($sformatf("mdl%0d_done", k),  32'(o_dn(k)),  32'(m_done[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input int k, input string name, input logic [3:0] d,
                            input logic v, input logic b, input logic dn);
    check({name, "_digit"}, 32'(o_dig(k)), 32'(d));
    check({name, "_valid"}, 32'(o_val(k)), 32'(v));
    check({name, "_busy"},  32'(o_bsy(k)), 32'(b));
    check({name, "_done"},  32'(o_dn(k)),  32'(dn));
  endtask

  task automatic loopback(input int k, input logic [11:0] code);
    logic [11:0] rx;
    int          n;
    bit          seen;
    logic        r;
    rx = '0; n = 0; seen = 0;
    tick();
    if (k == 0) begin load0 = 1; pw0 = code; ready0 = 0; end
    else        begin load2 = 1; pw2 = code; ready2 = 0; end
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      load0 = 0; load2 = 0;
      if (o_dn(k)) begin
        seen = 1;
      end else begin
        r = 1'($urandom_range(0, 1));
        if (k == 0) ready0 = r; else ready2 = r;
        if (o_val(k) && r) begin
          rx = {rx[7:0], o_dig(k)};
          n++;
        end
      end
    end
    check($sformatf("lb%0d_%03h_done_seen", k, code), 32'(seen), 32'd1);
    check($sformatf("lb%0d_%03h_code", k, code), 32'(rx), 32'(code));
    check($sformatf("lb%0d_%03h_strobes", k, code), 32'(n), 32'd3);
    ready0 = 0; ready2 = 0;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    expect_out(0, "rst0", 4'h0, 0, 0, 0);
    expect_out(1, "rst2", 4'h0, 0, 0, 0);
    rst = 0;
    tick();

    // 1: 3A7, ready high, no gap
    load0 = 1; pw0 = 12'h3A7; ready0 = 1;
    tick(); load0 = 0;
    expect_out(0, "t1_c1", 4'h3, 1, 1, 0);
    tick(); expect_out(0, "t1_c2", 4'hA, 1, 1, 0);
    tick(); expect_out(0, "t1_c3", 4'h7, 1, 1, 0);
    tick(); expect_out(0, "t1_c4", 4'h0, 0, 1, 1);
    tick(); expect_out(0, "t1_c5", 4'h0, 0, 0, 0);

    // 2: backpressure on first digit
    load0 = 1; pw0 = 12'h3A7; ready0 = 0;
    tick(); load0 = 0;
    expect_out(0, "t2_c1", 4'h3, 1, 1, 0);
    tick(); expect_out(0, "t2_c2", 4'h3, 1, 1, 0);
    tick(); expect_out(0, "t2_c3", 4'h3, 1, 1, 0);
    tick(); ready0 = 1;
    expect_out(0, "t2_c4", 4'h3, 1, 1, 0);
    tick(); expect_out(0, "t2_c5", 4'hA, 1, 1, 0);
    tick(); expect_out(0, "t2_c6", 4'h7, 1, 1, 0);
    tick(); expect_out(0, "t2_c7", 4'h0, 0, 1, 1);
    tick(); expect_out(0, "t2_c8", 4'h0, 0, 0, 0);

    // 3: two-cycle gaps, trailing zero digit
    load2 = 1; pw2 = 12'h5E0; ready2 = 1;
    tick(); load2 = 0;
    expect_out(1, "t3_c1", 4'h5, 1, 1, 0);
    tick(); expect_out(1, "t3_c2", 4'h0, 0, 1, 0);
    tick(); expect_out(1, "t3_c3", 4'h0, 0, 1, 0);
    tick(); expect_out(1, "t3_c4", 4'hE, 1, 1, 0);
    tick(); expect_out(1, "t3_c5", 4'h0, 0, 1, 0);
    tick(); expect_out(1, "t3_c6", 4'h0, 0, 1, 0);
    tick(); expect_out(1, "t3_c7", 4'h0, 1, 1, 0);
    tick(); expect_out(1, "t3_c8", 4'h0, 0, 1, 1);
    tick(); expect_out(1, "t3_c9", 4'h0, 0, 0, 0);
    ready2 = 0;

    // 4: loads while busy (mid-stream and in DONE) are ignored
    load0 = 1; pw0 = 12'h123; ready0 = 1;
    tick(); load0 = 0;
    expect_out(0, "t4_c1", 4'h1, 1, 1, 0);
    tick(); load0 = 1; pw0 = 12'hFFF;
    expect_out(0, "t4_c2", 4'h2, 1, 1, 0);
    tick(); load0 = 0;
    expect_out(0, "t4_c3", 4'h3, 1, 1, 0);
    tick(); load0 = 1;
    expect_out(0, "t4_c4", 4'h0, 0, 1, 1);
    tick(); load0 = 0;
    expect_out(0, "t4_c5", 4'h0, 0, 0, 0);
    tick(); expect_out(0, "t4_c6", 4'h0, 0, 0, 0);

    // 5: reset mid-stream, then a fresh load
    load0 = 1; pw0 = 12'h3A7; ready0 = 1;
    tick(); load0 = 0;
    expect_out(0, "t5_c1", 4'h3, 1, 1, 0);
    tick(); rst = 1;
    expect_out(0, "t5_c2", 4'hA, 1, 1, 0);
    tick(); rst = 0;
    expect_out(0, "t5_rst", 4'h0, 0, 0, 0);
    tick(); load0 = 1; pw0 = 12'h456;
    tick(); load0 = 0;
    expect_out(0, "t5_n1", 4'h4, 1, 1, 0);
    tick(); expect_out(0, "t5_n2", 4'h5, 1, 1, 0);
    tick(); expect_out(0, "t5_n3", 4'h6, 1, 1, 0);
    tick(); expect_out(0, "t5_n4", 4'h0, 0, 1, 1);
    tick(); ready0 = 0;

    // 6: loopback with random ready
    loopback(0, 12'h9C1);
    loopback(0, 12'hFFF);
    loopback(1, 12'h9C1);
    loopback(1, 12'hFFF);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
